// File: rtl/fsm_bluetooth_pkg.sv
// Shared definitions for the byte-framed serial transmitter: the FSM state
// encoding, the parity-mode encodings and small parity helpers.
package fsm_bluetooth;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4
    } tx_state_t;

    // in_parity_mode encodings; 2'b11 is a second spelling of "no parity"
    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    // True when the mode inserts a parity bit after the data bits
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Parity bit for one data byte: even = XOR of the bits, odd = its inverse
    function automatic logic parity_of(input logic [7:0] data, input logic [1:0] mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/bluetooth_tx_fifo.sv
// Word buffer in front of the serialiser. The head word is visible on
// rd_data whenever the buffer is non-empty, so the transmitter can pop and
// load it on the same edge. Pointers wrap naturally because DEPTH is a
// power of two.
module bluetooth_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level_reg == LVL_FULL);
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_reg];

    // Storage array: written only on an accepted write, never reset
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; a simultaneous write and read keeps the level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/bluetooth_frame_tx.sv
// Buffered word transmitter: each N_BITS word leaves as N_BITS/8 UART-style
// byte frames (start, 8 data bits LSB first, optional parity, 1 or 2 stop
// bits), least-significant byte first. Framing options are sampled when a
// word is popped and held for the whole word.
module bluetooth_frame_tx
    import fsm_bluetooth::*;
#(
    parameter int N_BITS       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 5000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_tx_valid,
    input  logic [N_BITS-1:0]                 in_tx_data,
    output logic                              out_tx_ready,
    input  logic [1:0]                        in_parity_mode,
    input  logic                              in_two_stop,
    output logic                              out_tx_serial,
    output logic                              out_tx_active,
    output logic                              out_tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   out_fifo_level
);

    localparam int N_BYTES = N_BITS / 8;
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W  = $clog2(N_BYTES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N_BYTES - 1);

    // Buffer interface
    logic              fifo_full;
    logic              fifo_empty;
    logic [N_BITS-1:0] fifo_rd_data;
    logic              fifo_wr;
    logic              pop;

    // Serialiser state
    tx_state_t         state_reg;
    logic [CNT_W-1:0]  clk_cnt_reg;
    logic [2:0]        bit_idx_reg;
    logic              stop_idx_reg;
    logic [BYTE_W-1:0] byte_idx_reg;
    logic [N_BITS-1:0] shift_reg;
    logic [1:0]        par_mode_reg;
    logic              two_stop_reg;
    logic              par_bit_reg;
    logic              serial_reg;
    logic              active_reg;
    logic              done_reg;
    logic              bit_end;

    assign out_tx_ready  = !fifo_full;
    assign fifo_wr       = in_tx_valid && out_tx_ready;
    assign pop           = (state_reg == IDLE) && !fifo_empty;
    assign bit_end       = (clk_cnt_reg == CNT_LAST);
    assign out_tx_serial = serial_reg;
    assign out_tx_active = active_reg;
    assign out_tx_done   = done_reg;

    bluetooth_tx_fifo #(
        .WIDTH (N_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (in_tx_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .level   (out_fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Frame sequencer: every non-idle state lasts whole bit periods, and the
    // serial line is updated on the same edge as the state so they stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            clk_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            byte_idx_reg <= '0;
            shift_reg    <= '0;
            par_mode_reg <= PAR_NONE;
            two_stop_reg <= 1'b0;
            par_bit_reg  <= 1'b0;
            serial_reg   <= 1'b1;
            active_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg != IDLE) begin
                clk_cnt_reg <= bit_end ? '0 : clk_cnt_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    serial_reg <= 1'b1;
                    if (pop) begin
                        shift_reg    <= fifo_rd_data;
                        par_mode_reg <= in_parity_mode;
                        two_stop_reg <= in_two_stop;
                        par_bit_reg  <= parity_of(fifo_rd_data[7:0], in_parity_mode);
                        byte_idx_reg <= '0;
                        clk_cnt_reg  <= '0;
                        serial_reg   <= 1'b0;
                        active_reg   <= 1'b1;
                        state_reg    <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (bit_end) begin
                        serial_reg  <= shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[N_BITS-1:1]};
                        bit_idx_reg <= '0;
                        state_reg   <= DATA_BITS;
                    end
                end
                DATA_BITS: begin
                    if (bit_end) begin
                        if (bit_idx_reg == 3'd7) begin
                            if (parity_enabled(par_mode_reg)) begin
                                serial_reg <= par_bit_reg;
                                state_reg  <= PARITY_BIT;
                            end else begin
                                serial_reg   <= 1'b1;
                                stop_idx_reg <= 1'b0;
                                state_reg    <= STOP_BIT;
                            end
                        end else begin
                            serial_reg  <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[N_BITS-1:1]};
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end
                end
                PARITY_BIT: begin
                    if (bit_end) begin
                        serial_reg   <= 1'b1;
                        stop_idx_reg <= 1'b0;
                        state_reg    <= STOP_BIT;
                    end
                end
                STOP_BIT: begin
                    if (bit_end) begin
                        if (two_stop_reg && !stop_idx_reg) begin
                            stop_idx_reg <= 1'b1;
                        end else if (byte_idx_reg == BYTE_LAST) begin
                            serial_reg <= 1'b1;
                            active_reg <= 1'b0;
                            done_reg   <= 1'b1;
                            state_reg  <= IDLE;
                        end else begin
                            // shift_reg has already moved eight places, so its low byte is next
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                            par_bit_reg  <= parity_of(shift_reg[7:0], par_mode_reg);
                            serial_reg   <= 1'b0;
                            state_reg    <= START_BIT;
                        end
                    end
                end
                default: begin
                    serial_reg <= 1'b1;
                    active_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bluetooth_frame_tx.sv
// Self-checking bench for bluetooth_frame_tx with CLKS_PER_BIT=4. The
// reference builds the expected line waveform of a whole word directly from
// the framing rules and compares it cycle by cycle.
module tb_bluetooth_frame_tx;

    localparam int N_BITS     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int CPB        = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_tx_valid = 1'b0;
    logic [N_BITS-1:0] in_tx_data = '0;
    logic [1:0]        in_parity_mode = 2'b00;
    logic              in_two_stop = 1'b0;
    logic              out_tx_ready;
    logic              out_tx_serial;
    logic              out_tx_active;
    logic              out_tx_done;
    logic [LVL_W-1:0]  out_fifo_level;

    int checks = 0;
    int failures = 0;

    bit exp_q[$];
    bit obs [0:511];
    int obs_len;

    always #5 clk = ~clk;

    bluetooth_frame_tx #(
        .N_BITS       (N_BITS),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_tx_valid    (in_tx_valid),
        .in_tx_data     (in_tx_data),
        .out_tx_ready   (out_tx_ready),
        .in_parity_mode (in_parity_mode),
        .in_two_stop    (in_two_stop),
        .out_tx_serial  (out_tx_serial),
        .out_tx_active  (out_tx_active),
        .out_tx_done    (out_tx_done),
        .out_fifo_level (out_fifo_level)
    );

    // One line bit repeated for a full bit period
    task automatic push_bit(input bit v);
        for (int k = 0; k < CPB; k++) exp_q.push_back(v);
    endtask

    // Reference waveform of one word, straight from the framing rules
    task automatic build_expected(input logic [N_BITS-1:0] word, input logic [1:0] mode,
                                  input logic two_stop);
        logic [7:0] byt;
        exp_q.delete();
        for (int b = 0; b < N_BITS / 8; b++) begin
            byt = word[8*b +: 8];
            push_bit(1'b0);
            for (int j = 0; j < 8; j++) push_bit(byt[j]);
            if (mode == 2'b01) push_bit(^byt);
            if (mode == 2'b10) push_bit(~^byt);
            push_bit(1'b1);
            if (two_stop) push_bit(1'b1);
        end
    endtask

    // Single-cycle write of one word with its framing options
    task automatic enqueue(input logic [N_BITS-1:0] word, input logic [1:0] mode,
                           input logic two_stop);
        @(negedge clk);
        in_tx_valid    = 1'b1;
        in_tx_data     = word;
        in_parity_mode = mode;
        in_two_stop    = two_stop;
        @(negedge clk);
        in_tx_valid = 1'b0;
    endtask

    // Wait for the word to start, then compare every line cycle and the done pulse
    task automatic check_word(input logic [N_BITS-1:0] word, input logic [1:0] mode,
                              input logic two_stop, input bit scramble, output int waited);
        int bad;
        build_expected(word, mode, two_stop);
        waited  = 0;
        obs_len = 0;
        bad     = 0;
        while (waited < 400) begin
            @(negedge clk);
            waited++;
            if (out_tx_active === 1'b1) break;
        end
        checks++;
        if (out_tx_active !== 1'b1) begin
            failures++;
            $display("FAIL start_timeout word=%h active=%b required active=1 within 400 cycles",
                     word, out_tx_active);
            return;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            obs[i] = out_tx_serial;
            obs_len++;
            checks++;
            if (out_tx_serial !== exp_q[i] || out_tx_active !== 1'b1 || out_tx_done !== 1'b0) begin
                failures++;
                bad++;
                $display("FAIL line_cycle%0d word=%h got serial=%b active=%b done=%b required serial=%b active=1 done=0",
                         i, word, out_tx_serial, out_tx_active, out_tx_done, exp_q[i]);
            end
            if (scramble) begin
                in_parity_mode = 2'($urandom_range(3));
                in_two_stop    = 1'($urandom_range(1));
            end
        end
        @(negedge clk);
        checks++;
        if (out_tx_done !== 1'b1 || out_tx_serial !== 1'b1 || out_tx_active !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse word=%h got done=%b serial=%b active=%b required done=1 serial=1 active=0",
                     word, out_tx_done, out_tx_serial, out_tx_active);
        end
        $display("tx word=%h mode=%0d two_stop=%0d cycles=%0d bad_cycles=%0d",
                 word, mode, two_stop, obs_len, bad);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_tx_serial !== 1'b1) begin
            failures++;
            $display("FAIL reset_serial got %b required 1", out_tx_serial);
        end
        checks++;
        if (out_tx_active !== 1'b0 || out_tx_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got active=%b done=%b required 0 0", out_tx_active, out_tx_done);
        end
        checks++;
        if (out_fifo_level !== '0 || out_tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_fifo got level=%0d ready=%b required 0 1", out_fifo_level, out_tx_ready);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_basic();
        int w;
        enqueue(32'hA5C30F81, 2'b00, 1'b0);
        check_word(32'hA5C30F81, 2'b00, 1'b0, 1'b0, w);
        checks++;
        if (obs_len != 160 || obs[39] !== 1'b1 || obs[40] !== 1'b0) begin
            failures++;
            $display("FAIL basic_frame_len got len=%0d stop=%b next_start=%b required 160 1 0",
                     obs_len, obs[39], obs[40]);
        end
    endtask

    task automatic test_parity();
        int w;
        logic [N_BITS-1:0] word;
        word = {$urandom_range(32'h00FFFFFF), 8'h00} | 32'h81;
        enqueue(word, 2'b01, 1'b0);
        check_word(word, 2'b01, 1'b0, 1'b0, w);
        checks++;
        if (obs[38] !== 1'b0 || obs[43] !== 1'b1 || obs[44] !== 1'b0) begin
            failures++;
            $display("FAIL parity_even got parity=%b stop=%b next_start=%b required 0 1 0",
                     obs[38], obs[43], obs[44]);
        end
        enqueue(word, 2'b10, 1'b0);
        check_word(word, 2'b10, 1'b0, 1'b0, w);
        checks++;
        if (obs[38] !== 1'b1 || obs[44] !== 1'b0) begin
            failures++;
            $display("FAIL parity_odd got parity=%b next_start=%b required 1 0", obs[38], obs[44]);
        end
        enqueue(word, 2'b11, 1'b0);
        check_word(word, 2'b11, 1'b0, 1'b0, w);
    endtask

    task automatic test_two_stop();
        int w;
        int highs;
        logic [N_BITS-1:0] word;
        word = $urandom;
        enqueue(word, 2'b00, 1'b1);
        check_word(word, 2'b00, 1'b1, 1'b1, w);
        highs = 0;
        for (int i = 36; i < 44; i++) highs += int'(obs[i]);
        checks++;
        if (highs != 8 || obs[44] !== 1'b0) begin
            failures++;
            $display("FAIL two_stop_gap got high_cycles=%0d next_start=%b required 8 0", highs, obs[44]);
        end
        word = $urandom;
        enqueue(word, 2'b10, 1'b0);
        check_word(word, 2'b10, 1'b0, 1'b1, w);
    endtask

    task automatic test_back_to_back();
        logic [N_BITS-1:0] words [8];
        logic [1:0] mode;
        logic       ts;
        int acc;
        int idx;
        mode = 2'($urandom_range(3));
        ts   = 1'($urandom_range(1));
        for (int i = 0; i < 8; i++) words[i] = ($urandom & 32'h00FFFFFF) | (i << 24);
        acc = 0;
        idx = 0;
        in_parity_mode = mode;
        in_two_stop    = ts;
        fork
            begin
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    in_tx_valid = 1'b1;
                    in_tx_data  = words[idx];
                    if (out_tx_ready) begin
                        acc++;
                        idx++;
                    end
                end
                @(negedge clk);
                in_tx_valid = 1'b0;
                checks++;
                if (out_tx_ready !== 1'b0 || out_fifo_level !== LVL_W'(FIFO_DEPTH)) begin
                    failures++;
                    $display("FAIL fill_full got ready=%b level=%0d required 0 %0d",
                             out_tx_ready, out_fifo_level, FIFO_DEPTH);
                end
            end
            begin
                int w;
                for (int k = 0; k < FIFO_DEPTH + 1; k++) begin
                    check_word(words[k], mode, ts, 1'b0, w);
                    if (k > 0) begin
                        checks++;
                        if (w != 1) begin
                            failures++;
                            $display("FAIL idle_gap word%0d got %0d idle cycles required 1", k, w);
                        end
                    end
                end
            end
        join
        checks++;
        if (acc != FIFO_DEPTH + 1) begin
            failures++;
            $display("FAIL fill_accepted got %0d required %0d", acc, FIFO_DEPTH + 1);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        int w;
        logic [N_BITS-1:0] word;
        enqueue($urandom, 2'b01, 1'b0);
        enqueue($urandom, 2'b01, 1'b0);
        repeat (50) @(negedge clk);
        checks++;
        if (out_tx_active !== 1'b1 || out_fifo_level !== LVL_W'(1)) begin
            failures++;
            $display("FAIL pre_reset got active=%b level=%0d required 1 1", out_tx_active, out_fifo_level);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_tx_serial !== 1'b1 || out_tx_active !== 1'b0 || out_tx_done !== 1'b0 ||
            out_fifo_level !== '0 || out_tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got serial=%b active=%b done=%b level=%0d ready=%b required 1 0 0 0 1",
                     out_tx_serial, out_tx_active, out_tx_done, out_fifo_level, out_tx_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_tx_done !== 1'b0 || out_tx_serial !== 1'b1 || out_tx_active !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL post_reset_quiet got %0d non-idle cycles required 0", bad);
        end
        word = $urandom;
        enqueue(word, 2'b00, 1'b1);
        check_word(word, 2'b00, 1'b1, 1'b0, w);
    endtask

    task automatic test_random();
        int w;
        logic [N_BITS-1:0] word;
        logic [1:0] mode;
        logic ts;
        for (int n = 0; n < 6; n++) begin
            word = $urandom;
            mode = 2'($urandom_range(3));
            ts   = 1'($urandom_range(1));
            enqueue(word, mode, ts);
            check_word(word, mode, ts, 1'($urandom_range(1)), w);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
